// File: rtl/iic_cmd_arbiter_if.sv
// rtl/iic_cmd_arbiter_if.sv - requester/engine bundle for the I2C command arbiter
interface iic_cmd_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_chip;
    logic [8*N_REQ-1:0] req_reg;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               ack_err;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               start_sys;
    logic [7:0]         chip_byte;
    logic [7:0]         reg_byte;
    logic [7:0]         data_byte;
    logic               eng_done;
    logic               eng_abort;

    // master: the arbiter itself
    modport master (
        input  req, req_chip, req_reg, req_data, eng_done,
        output ack, ack_err, grant, busy, start_sys,
               chip_byte, reg_byte, data_byte, eng_abort
    );

    // slave: requesters plus the transaction engine
    modport slave (
        output req, req_chip, req_reg, req_data, eng_done,
        input  ack, ack_err, grant, busy, start_sys,
               chip_byte, reg_byte, data_byte, eng_abort
    );
endinterface

// File: rtl/iic_cmd_arbiter.sv
// rtl/iic_cmd_arbiter.sv - round-robin sharing of the I2C transaction engine among register-write requesters
module iic_cmd_arbiter #(
    parameter int          N_REQ   = 4,
    parameter int          TO_W    = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rstn,
    iic_cmd_arbiter_if.master bus
);
    localparam int IDXW = $clog2(N_REQ);
    // Abort fires in the (TIMEOUT+1)-th WAIT cycle, so the error ack lands TIMEOUT+2 cycles after start_sys.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [TO_W-1:0]   count_q;
    logic [7:0]        chip_q;
    logic [7:0]        reg_q;
    logic [7:0]        data_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  ack_q;
    logic              ack_err_q;
    logic              busy_q;
    logic              start_q;
    logic              abort_q;

    logic              found;
    logic [IDXW-1:0]   sel;

    // Circular search from rr_ptr for the first active request.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [IDXW-1:0] cand;
            cand = IDXW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            count_q   <= '0;
            chip_q    <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            abort_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        idx_q   <= sel;
                        chip_q  <= bus.req_chip[int'(sel)*8 +: 8];
                        reg_q   <= bus.req_reg[int'(sel)*8 +: 8];
                        data_q  <= bus.req_data[int'(sel)*8 +: 8];
                        grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    count_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    count_q <= count_q + 1'b1;
                    if (bus.eng_done) begin
                        ack_q   <= grant_q;
                        state_q <= S_DONE;
                    end else if (count_q == TO_LAST) begin
                        ack_q     <= grant_q;
                        ack_err_q <= 1'b1;
                        abort_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr_q <= (idx_q == IDXW'(N_REQ-1)) ? '0 : idx_q + 1'b1;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.start_sys = start_q;
    assign bus.chip_byte = chip_q;
    assign bus.reg_byte  = reg_q;
    assign bus.data_byte = data_q;
    assign bus.eng_abort = abort_q;
endmodule
